// File: rtl/puc_pkg.sv
// puc_pkg: shared widths, instruction field layout and store state encoding for the fetch-side program store.
package puc_pkg;
   localparam int PC_WIDTH          = 4;
   localparam int INSTRUCTION_WIDTH = 12;
   localparam int REGISTER_WIDTH    = 8;
   localparam int STORE_DEPTH       = 16;
   localparam int OPERAND_LSB       = 0;
   localparam int OPCODE_LSB        = REGISTER_WIDTH;
   localparam int OPCODE_MSB        = INSTRUCTION_WIDTH - 1;
   localparam int OPCODE_WIDTH      = OPCODE_MSB - OPCODE_LSB + 1;

   typedef logic [INSTRUCTION_WIDTH-1:0] instruction_t;
   typedef logic [OPCODE_WIDTH-1:0]      opcode_t;
   typedef enum logic {LOAD, RUN}        store_state_t;

   localparam opcode_t      OPCODE_HALT      = 4'hF;
   localparam instruction_t HALT_INSTRUCTION = {OPCODE_HALT, {REGISTER_WIDTH{1'b0}}};
endpackage

// File: rtl/instruction_store_program_ram.sv
// program_ram: single-clock word array with one write port and a registered read port.
// Contents are never reset; only the read register returns to zero.
module program_ram
   import puc_pkg::*;
#(
   parameter int DEPTH = STORE_DEPTH
) (
   input  logic                clock,
   input  logic                isReset,
   input  logic                i_write_enable,
   input  logic [PC_WIDTH-1:0] i_write_address,
   input  instruction_t        i_write_data,
   input  logic                i_read_enable,
   input  logic [PC_WIDTH-1:0] i_read_address,
   output instruction_t        o_read_data
);
   instruction_t r_mem [DEPTH];
   instruction_t r_read_data;

   always_ff @(posedge clock)
      if (i_write_enable) r_mem[i_write_address] <= i_write_data;

   always_ff @(posedge clock)
      if (!isReset) r_read_data <= '0;
      else if (i_read_enable) r_read_data <= r_mem[i_read_address];

   assign o_read_data = r_read_data;
endmodule

// File: rtl/instruction_store.sv
// instruction_store: loader-fed program memory serving one-cycle registered fetches by pc.
// Fetches at or beyond the loaded length return the HALT word instead of the array.
module instruction_store
   import puc_pkg::*;
#(
   parameter int DEPTH = STORE_DEPTH
) (
   input  logic                clock,
   input  logic                isReset,
   input  logic                loadValid,
   output logic                loadReady,
   input  instruction_t        loadData,
   input  logic                loadLast,
   input  logic                reloadRequest,
   input  logic [PC_WIDTH-1:0] pc,
   input  logic                fetchRequest,
   output instruction_t        instruction,
   output logic                instructionValid,
   output logic                cpuHold,
   output logic [PC_WIDTH:0]   programLength,
   output logic                overflowError
);
   localparam logic [PC_WIDTH-1:0] LAST_ADDRESS = PC_WIDTH'(DEPTH - 1);

   store_state_t        r_state;
   logic [PC_WIDTH-1:0] r_write_address;
   logic [PC_WIDTH:0]   r_program_length;
   logic                r_valid;
   logic                r_hold;
   logic                r_overflow;
   logic                r_halt_select;
   logic                w_beat;
   logic                w_fetch;
   logic                w_in_range;
   logic                w_at_end;
   instruction_t        w_ram_data;

   assign loadReady  = (r_state == LOAD);
   assign w_beat     = loadValid && loadReady;
   assign w_fetch    = (r_state == RUN) && fetchRequest && !reloadRequest;
   // programLength never exceeds DEPTH, so this also rejects any pc outside the array
   assign w_in_range = {1'b0, pc} < r_program_length;
   assign w_at_end   = (r_write_address == LAST_ADDRESS);

   program_ram #(.DEPTH(DEPTH)) u_ram (
      .clock           (clock),
      .isReset         (isReset),
      .i_write_enable  (w_beat),
      .i_write_address (r_write_address),
      .i_write_data    (loadData),
      .i_read_enable   (w_fetch && w_in_range),
      .i_read_address  (pc),
      .o_read_data     (w_ram_data)
   );

   always_ff @(posedge clock) begin
      if (!isReset) begin
         r_state          <= LOAD;
         r_write_address  <= '0;
         r_program_length <= '0;
         r_valid          <= 1'b0;
         r_hold           <= 1'b1;
         r_overflow       <= 1'b0;
         r_halt_select    <= 1'b0;
      end else if (r_state == LOAD) begin
         r_valid <= 1'b0;
         if (w_beat) begin
            r_write_address  <= r_write_address + 1'b1;
            r_program_length <= {1'b0, r_write_address} + 1'b1;
            if (loadLast || w_at_end) begin
               r_state <= RUN;
               r_hold  <= 1'b0;
            end
            if (!loadLast && w_at_end) r_overflow <= 1'b1;
         end
      end else begin
         r_valid <= w_fetch;
         if (w_fetch) r_halt_select <= !w_in_range;
         if (reloadRequest) begin
            r_state          <= LOAD;
            r_write_address  <= '0;
            r_program_length <= '0;
            r_hold           <= 1'b1;
            r_overflow       <= 1'b0;
         end
      end
   end

   assign instruction      = r_halt_select ? HALT_INSTRUCTION : w_ram_data;
   assign instructionValid = r_valid;
   assign cpuHold          = r_hold;
   assign programLength    = r_program_length;
   assign overflowError    = r_overflow;
endmodule
